dvp_capture_dual: RTL and testbench
===================================

# dvp_capture_dual

Dual-camera DVP receiver. Samples the shared VSYNC/HREF strobes and the two 8-bit byte buses (D1, D2) of a DVP camera pair, pairs bytes into 16-bit YCbCr 4:2:2 words and emits a synchronous pixel stream with frame/line markers and coordinates. It sits between the camera pins (or the DVP imitator in simulation) and the HDR merge pipeline, on the pclk domain.

## Interface
- H_PIX, 1280: active pixels per line (2 bytes each, 2560 HREF-high cycles)
- V_LINES, 720: active lines per frame
- pclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  capture enable, sampled at frame start only
- VSYNC  in  1  frame strobe, high during vertical sync
- HREF  in  1  line strobe, high during active bytes
- D1  in  8  camera-1 byte bus
- D2  in  8  camera-2 byte bus
- pix_valid  out  1  pix1/pix2 hold a valid pixel this cycle
- pix1  out  16  camera-1 pixel, {first byte, second byte}
- pix2  out  16  camera-2 pixel, same ordering
- sof  out  1  with pix_valid on pixel (0,0)
- eol  out  1  with pix_valid on last pixel of a line
- eof  out  1  with eol on last pixel of line V_LINES-1
- pix_x  out  11  column of current pixel
- line_y  out  10  row of current pixel
- frame_cnt  out  6  completed frames, wraps 63->0
- err_line_len  out  1  sticky; present only with DVP_CAP_CHECK_EN
- err_frame_len  out  1  sticky; present only with DVP_CAP_CHECK_EN

## Operation
- Input stage: VSYNC, HREF, D1, D2 registered once (s_*); all decisions use registered copies; edges detected against a second delay.
- States: IDLE, WAIT_VS_FALL, WAIT_LINE, LINE, FRAME_END.
- IDLE: on s_VSYNC rising edge with enable=1 -> WAIT_VS_FALL; line_y<=0. enable=0 stays IDLE.
- WAIT_VS_FALL: on s_VSYNC falling -> WAIT_LINE. HREF ignored while VSYNC high.
- WAIT_LINE: on s_HREF rising -> LINE; byte phase<=0, pix_x<=0.
- LINE: each s_HREF-high cycle toggles byte phase; phase 0 latches high byte, phase 1 completes the word for both cameras and issues a pixel. On s_HREF falling -> line_y+1, WAIT_LINE; after line V_LINES-1 -> FRAME_END.
- FRAME_END: one cycle; frame_cnt+1; -> WAIT_VS_FALL if next VSYNC rising already seen and enable=1, else IDLE (waits for VSYNC rising).
- Pixels beyond H_PIX in a line and lines beyond V_LINES are dropped (no pix_valid).
- Odd byte count at HREF fall: dangling byte discarded.
- s_VSYNC rising in any state other than IDLE/FRAME_END: frame aborted, no eof, restart at WAIT_VS_FALL (if enable=1) else IDLE; frame_cnt not incremented.
- enable deasserted mid-frame: current frame completes, then IDLE.

## Timing
- Reset: pix_valid, sof, eol, eof, pix1, pix2, pix_x, line_y, frame_cnt, err_* all 0; state IDLE. Reset mid-frame discards the frame; capture resumes only at next VSYNC rising edge.
- Latency: second byte of a pair on pins before edge k -> pix_valid high in cycle after edge k+2 (input reg, pair reg, output reg). Fixed, no backpressure.
- pix_valid at most every other cycle; sof/eol/eof are single-cycle, only with pix_valid.
- frame_cnt updates the cycle after eof.

## Configuration
- DVP_CAP_CHECK_EN defined: err_line_len sets when a line closes with byte count != 2*H_PIX; err_frame_len sets when VSYNC rises with line_y != V_LINES or aborts a frame. Both sticky until reset.
- Undefined: check counters and err ports removed; data path behaviour identical.

## Structure
- Package dvp_pkg: state enum typedef, DVP_H_PIX=1280, DVP_V_LINES=720, DVP_LINE_PERIOD=5688 (bench use), pixel width constant.
- Sub-module dvp_byte_pair: per-camera byte-to-16-bit assembler (phase, high-byte reg, word out, valid); instantiated twice, phase shared.

## Test plan
- Imitator frame 1280x720, D1=0x10,0x80 repeating -> 921600 pix_valid, every pix1=0x1080, one sof, 720 eol, one eof with pix_x=1279 line_y=719, frame_cnt=1.
- Three back-to-back frames -> frame_cnt=3, sof count 3, no errors.
- Line of 2561 bytes (odd) with check enabled -> 1280 pixels, last byte dropped, err_line_len=1.
- VSYNC rising after line 400 -> no eof, frame_cnt unchanged, err_frame_len=1, next full frame captured normally.
- reset pulse at line 100 -> all outputs 0 next cycle; no pix_valid until after the following VSYNC rise/fall; that frame is complete.
- enable=0 at VSYNC rise -> zero pix_valid for that frame; enable=1 before next VSYNC -> next frame captured.

Source files
------------

// File: rtl/dvp_pkg.sv
// dvp_pkg: shared types and constants for the dual-camera DVP receiver.
//   dvp_state_t     capture state machine encoding
//   DVP_H_PIX       active pixels per line (two bytes per pixel)
//   DVP_V_LINES     active lines per frame
//   DVP_LINE_PERIOD pclk cycles per line including blanking (stimulus use)
//   DVP_PIX_W       width of one assembled YCbCr 4:2:2 word
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VS_FALL,
        ST_WAIT_LINE,
        ST_LINE,
        ST_FRAME_END
    } dvp_state_t;

    localparam int DVP_H_PIX       = 1280;
    localparam int DVP_V_LINES     = 720;
    localparam int DVP_LINE_PERIOD = 5688;
    localparam int DVP_PIX_W       = 16;

endpackage

// File: rtl/dvp_byte_pair.sv
// dvp_byte_pair: per-camera byte-to-word assembler.
//   clk, srst  clock and synchronous active-high reset
//   byte_en    a byte is present on din this cycle
//   phase      0: din is the high byte, 1: din completes the word
//   issue      word may be emitted (pixel lies inside the active width)
//   din        registered camera byte
//   word       {high byte, low byte}, held until the next completed pair
//   valid      one-cycle strobe, word updated on the previous edge
module dvp_byte_pair
    import dvp_pkg::*;
(
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 byte_en,
    input  logic                 phase,
    input  logic                 issue,
    input  logic [7:0]           din,
    output logic [DVP_PIX_W-1:0] word,
    output logic                 valid
);

    logic [7:0]           hi_reg;
    logic [DVP_PIX_W-1:0] word_reg;
    logic                 valid_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            hi_reg    <= '0;
            word_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= byte_en & phase & issue;
            if (byte_en && !phase) begin
                hi_reg <= din;
            end
            if (byte_en && phase && issue) begin
                word_reg <= {hi_reg, din};
            end
        end
    end

    assign word  = word_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/dvp_capture_dual.sv
// dvp_capture_dual: dual-camera DVP receiver producing a 16-bit pixel stream
// per camera with frame/line markers and coordinates.
//   pclk, reset          clock and synchronous active-high reset
//   enable               capture enable, sampled at frame start
//   VSYNC, HREF          shared frame / line strobes
//   D1, D2               camera byte buses
//   pix_valid, pix1/2    pixel strobe and assembled words
//   sof, eol, eof        frame start, line end, frame end markers
//   pix_x, line_y        coordinates of the current pixel
//   frame_cnt            completed frames (wraps)
//   err_line_len, err_frame_len  sticky length errors
// Optional build macro DVP_CAP_CHECK_EN adds the line/frame length checker
// and the two err_* ports; without it the data path is unchanged.
module dvp_capture_dual
    import dvp_pkg::*;
#(
    parameter int H_PIX   = DVP_H_PIX,
    parameter int V_LINES = DVP_V_LINES
) (
    input  logic                 pclk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 VSYNC,
    input  logic                 HREF,
    input  logic [7:0]           D1,
    input  logic [7:0]           D2,
    output logic                 pix_valid,
    output logic [DVP_PIX_W-1:0] pix1,
    output logic [DVP_PIX_W-1:0] pix2,
    output logic                 sof,
    output logic                 eol,
    output logic                 eof,
    output logic [10:0]          pix_x,
    output logic [9:0]           line_y,
    output logic [5:0]           frame_cnt
`ifdef DVP_CAP_CHECK_EN
    ,
    output logic                 err_line_len,
    output logic                 err_frame_len
`endif
);

    localparam int          CAMS   = 2;
    localparam logic [10:0] X_END  = 11'(H_PIX);
    localparam logic [10:0] X_LAST = 11'(H_PIX - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_LINES - 1);

    // ---------------- input stage ----------------
    logic s_vsync_reg, s_vsync_d_reg;
    logic s_href_reg,  s_href_d_reg;

    always_ff @(posedge pclk) begin
        if (reset) begin
            s_vsync_reg   <= 1'b0;
            s_vsync_d_reg <= 1'b0;
            s_href_reg    <= 1'b0;
            s_href_d_reg  <= 1'b0;
        end else begin
            s_vsync_reg   <= VSYNC;
            s_vsync_d_reg <= s_vsync_reg;
            s_href_reg    <= HREF;
            s_href_d_reg  <= s_href_reg;
        end
    end

    logic vs_rise, vs_fall, href_rise, href_fall;
    assign vs_rise   =  s_vsync_reg & ~s_vsync_d_reg;
    assign vs_fall   = ~s_vsync_reg &  s_vsync_d_reg;
    assign href_rise =  s_href_reg  & ~s_href_d_reg;
    assign href_fall = ~s_href_reg  &  s_href_d_reg;

    // ---------------- control ----------------
    dvp_state_t  state_reg;
    logic        phase_reg;
    logic [10:0] x_cnt_reg;
    logic [9:0]  y_cnt_reg;
    logic [5:0]  frame_cnt_reg;
    logic [10:0] pair_x_reg;
    logic [9:0]  pair_y_reg;
    logic        pair_sof_reg, pair_eol_reg, pair_eof_reg;

    logic line_start, byte_en, phase_cur, pix_issue, abort;

    // The HREF rising edge is seen in the same cycle the first byte sits in
    // the input register, so that byte is consumed as phase 0 right away and
    // LINE is entered with the phase already pointing at the low byte.
    assign line_start = (state_reg == ST_WAIT_LINE) && href_rise && !vs_rise;
    assign byte_en    = s_href_reg && !vs_rise && (line_start || state_reg == ST_LINE);
    assign phase_cur  = (state_reg == ST_LINE) && phase_reg;
    assign pix_issue  = byte_en && phase_cur && (x_cnt_reg < X_END);
    assign abort      = vs_rise && (state_reg == ST_WAIT_LINE || state_reg == ST_LINE);

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= 1'b0;
            x_cnt_reg     <= '0;
            y_cnt_reg     <= '0;
            frame_cnt_reg <= '0;
            pair_x_reg    <= '0;
            pair_y_reg    <= '0;
            pair_sof_reg  <= 1'b0;
            pair_eol_reg  <= 1'b0;
            pair_eof_reg  <= 1'b0;
        end else begin
            // Markers travel alongside the word in the pair stage.
            pair_sof_reg <= pix_issue && (x_cnt_reg == '0) && (y_cnt_reg == '0);
            pair_eol_reg <= pix_issue && (x_cnt_reg == X_LAST);
            pair_eof_reg <= pix_issue && (x_cnt_reg == X_LAST) && (y_cnt_reg == Y_LAST);
            if (pix_issue) begin
                pair_x_reg <= x_cnt_reg;
                pair_y_reg <= y_cnt_reg;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (vs_rise && enable) begin
                        state_reg <= ST_WAIT_VS_FALL;
                        y_cnt_reg <= '0;
                    end
                end
                ST_WAIT_VS_FALL: begin
                    if (vs_fall) begin
                        state_reg <= ST_WAIT_LINE;
                    end
                end
                ST_WAIT_LINE: begin
                    if (abort) begin
                        state_reg <= enable ? ST_WAIT_VS_FALL : ST_IDLE;
                        y_cnt_reg <= '0;
                    end else if (line_start) begin
                        state_reg <= ST_LINE;
                        phase_reg <= 1'b1;
                        x_cnt_reg <= '0;
                    end
                end
                ST_LINE: begin
                    if (abort) begin
                        state_reg <= enable ? ST_WAIT_VS_FALL : ST_IDLE;
                        y_cnt_reg <= '0;
                    end else if (href_fall) begin
                        y_cnt_reg <= y_cnt_reg + 10'd1;
                        state_reg <= (y_cnt_reg == Y_LAST) ? ST_FRAME_END : ST_WAIT_LINE;
                    end else if (byte_en) begin
                        phase_reg <= ~phase_reg;
                        if (pix_issue) begin
                            x_cnt_reg <= x_cnt_reg + 11'd1;
                        end
                    end
                end
                ST_FRAME_END: begin
                    frame_cnt_reg <= frame_cnt_reg + 6'd1;
                    if (vs_rise && enable) begin
                        state_reg <= ST_WAIT_VS_FALL;
                        y_cnt_reg <= '0;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // ---------------- per-camera assemblers ----------------
    logic [CAMS-1:0][7:0]           d_pins;
    logic [CAMS-1:0][DVP_PIX_W-1:0] pair_word;
    logic [CAMS-1:0]                pair_valid;

    assign d_pins = {D2, D1};

    genvar gi;
    generate
        for (gi = 0; gi < CAMS; gi++) begin : g_cam
            logic [7:0] s_d_reg;

            always_ff @(posedge pclk) begin
                if (reset) begin
                    s_d_reg <= '0;
                end else begin
                    s_d_reg <= d_pins[gi];
                end
            end

            dvp_byte_pair u_pair (
                .clk     (pclk),
                .srst    (reset),
                .byte_en (byte_en),
                .phase   (phase_cur),
                .issue   (pix_issue),
                .din     (s_d_reg),
                .word    (pair_word[gi]),
                .valid   (pair_valid[gi])
            );
        end
    endgenerate

    // ---------------- output stage ----------------
    always_ff @(posedge pclk) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix1      <= '0;
            pix2      <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            pix_x     <= '0;
            line_y    <= '0;
        end else begin
            pix_valid <= &pair_valid;
            sof       <= pair_sof_reg;
            eol       <= pair_eol_reg;
            eof       <= pair_eof_reg;
            if (&pair_valid) begin
                pix1   <= pair_word[0];
                pix2   <= pair_word[1];
                pix_x  <= pair_x_reg;
                line_y <= pair_y_reg;
            end
        end
    end

    assign frame_cnt = frame_cnt_reg;

`ifdef DVP_CAP_CHECK_EN
    // ---------------- length checker ----------------
    localparam logic [11:0] LINE_BYTES = 12'(2 * H_PIX);

    logic [11:0] byte_cnt_reg;
    logic        after_frame_reg, extra_line_reg;
    logic        err_line_reg, err_frame_reg;

    always_ff @(posedge pclk) begin
        if (reset) begin
            byte_cnt_reg    <= '0;
            after_frame_reg <= 1'b0;
            extra_line_reg  <= 1'b0;
            err_line_reg    <= 1'b0;
            err_frame_reg   <= 1'b0;
        end else begin
            // Saturating byte count of the current line.
            if (line_start) begin
                byte_cnt_reg <= 12'd1;
            end else if (byte_en && byte_cnt_reg != '1) begin
                byte_cnt_reg <= byte_cnt_reg + 12'd1;
            end
            if (state_reg == ST_LINE && href_fall && !vs_rise && byte_cnt_reg != LINE_BYTES) begin
                err_line_reg <= 1'b1;
            end
            // Lines arriving between frame completion and the next VSYNC
            // mean the frame was longer than V_LINES.
            if (vs_rise) begin
                after_frame_reg <= 1'b0;
            end else if (state_reg == ST_FRAME_END) begin
                after_frame_reg <= 1'b1;
            end
            if (vs_rise) begin
                extra_line_reg <= 1'b0;
            end else if (after_frame_reg && href_rise && !s_vsync_reg) begin
                extra_line_reg <= 1'b1;
            end
            if (abort || (vs_rise && extra_line_reg)) begin
                err_frame_reg <= 1'b1;
            end
        end
    end

    assign err_line_len  = err_line_reg;
    assign err_frame_len = err_frame_reg;
`endif

endmodule

// File: tb/tb_dvp_capture_dual.sv
module tb_dvp_capture_dual;

    localparam int H = 4;
    localparam int V = 3;

    logic        pclk = 1'b0;
    logic        reset, enable, VSYNC, HREF;
    logic [7:0]  D1, D2;
    logic        pix_valid, sof, eol, eof;
    logic [15:0] pix1, pix2;
    logic [10:0] pix_x;
    logic [9:0]  line_y;
    logic [5:0]  frame_cnt;
`ifdef DVP_CAP_CHECK_EN
    logic        err_line_len, err_frame_len;
`endif

    dvp_capture_dual #(.H_PIX(H), .V_LINES(V)) dut (
        .pclk      (pclk),
        .reset     (reset),
        .enable    (enable),
        .VSYNC     (VSYNC),
        .HREF      (HREF),
        .D1        (D1),
        .D2        (D2),
        .pix_valid (pix_valid),
        .pix1      (pix1),
        .pix2      (pix2),
        .sof       (sof),
        .eol       (eol),
        .eof       (eof),
        .pix_x     (pix_x),
        .line_y    (line_y),
        .frame_cnt (frame_cnt)
`ifdef DVP_CAP_CHECK_EN
        ,
        .err_line_len  (err_line_len),
        .err_frame_len (err_frame_len)
`endif
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- stream monitor with its own coordinate model ----------------
    int n_pix = 0, n_sof = 0, n_eol = 0, n_eof = 0, mon_err = 0;
    int exp_x = 0, exp_y = 0;
    int first_valid_cyc = 0, t_second = 0;
    int eof_x = 0, eof_y = 0, eof_fc = 0, post_fc = 0;
    bit grab_next = 0;

    always @(negedge pclk) begin
        logic [7:0] hb;
        logic       eol_e;
        if (VSYNC) begin
            exp_x = 0;
            exp_y = 0;
        end
        if (grab_next) begin
            post_fc   = int'(frame_cnt);
            grab_next = 0;
        end
        if (pix_valid) begin
            n_pix++;
            hb    = 8'(exp_y * 16 + 2 * exp_x);
            eol_e = (exp_x == H - 1);
            if (pix1 !== 16'h1080) mon_err++;
            if (pix2 !== {hb, hb + 8'd1}) mon_err++;
            if (pix_x !== 11'(exp_x) || line_y !== 10'(exp_y)) mon_err++;
            if (sof !== (exp_x == 0 && exp_y == 0)) mon_err++;
            if (eol !== eol_e) mon_err++;
            if (eof !== (eol_e && exp_y == V - 1)) mon_err++;
            if (sof) begin
                n_sof++;
                first_valid_cyc = cyc;
            end
            if (eol) n_eol++;
            if (eof) begin
                n_eof++;
                eof_x     = int'(pix_x);
                eof_y     = int'(line_y);
                eof_fc    = int'(frame_cnt);
                grab_next = 1;
            end
            if (exp_x == H - 1) begin
                exp_x = 0;
                exp_y++;
            end else begin
                exp_x++;
            end
        end else if (sof || eol || eof) begin
            mon_err++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic vsync_pulse();
        VSYNC = 1'b1;
        repeat (4) tick();
        VSYNC = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_line(input int l, input int nbytes);
        for (int j = 0; j < nbytes; j++) begin
            HREF = 1'b1;
            D1   = j[0] ? 8'h80 : 8'h10;
            D2   = 8'(l * 16 + j);
            if (l == 0 && j == 1) t_second = cyc;
            tick();
        end
        HREF = 1'b0;
        D1   = 8'h00;
        D2   = 8'h00;
        repeat (6) tick();
    endtask

    task automatic send_frame();
        vsync_pulse();
        for (int l = 0; l < V; l++) send_line(l, 2 * H);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
        check({tag, "_pix"},   {pix1, pix2}, 32'd0);
        check({tag, "_marks"}, {29'd0, sof, eol, eof}, 32'd0);
        check({tag, "_xy"},    {11'd0, pix_x, line_y}, 32'd0);
        check({tag, "_fcnt"},  {26'd0, frame_cnt}, 32'd0);
    endtask

    int p0, s0, l0, f0;
    task automatic snap();
        p0 = n_pix; s0 = n_sof; l0 = n_eol; f0 = n_eof;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; VSYNC = 1'b0; HREF = 1'b0; D1 = '0; D2 = '0;
        repeat (3) tick();
        @(negedge pclk);
        check_zero("rst");
`ifdef DVP_CAP_CHECK_EN
        check("rst_err", {30'd0, err_line_len, err_frame_len}, 32'd0);
`endif
        reset = 1'b0;
        tick();

        // single frame
        enable = 1'b1;
        snap();
        send_frame();
        check("f1_pix",     n_pix - p0, 12);
        check("f1_sof",     n_sof - s0, 1);
        check("f1_eol",     n_eol - l0, 3);
        check("f1_eof",     n_eof - f0, 1);
        check("f1_eof_xy",  {eof_x[15:0], eof_y[15:0]}, {16'd3, 16'd2});
        check("f1_fcnt",    frame_cnt, 1);
        check("f1_latency", first_valid_cyc - t_second, 3);
        check("f1_fc_eof",  eof_fc, 0);
        check("f1_fc_next", post_fc, 1);
        check("f1_stream",  mon_err, 0);

        // three back-to-back frames
        reset_pulse();
        snap();
        for (int f = 0; f < 3; f++) send_frame();
        check("b2b_fcnt",   frame_cnt, 3);
        check("b2b_sof",    n_sof - s0, 3);
        check("b2b_eof",    n_eof - f0, 3);
        check("b2b_pix",    n_pix - p0, 36);
        check("b2b_stream", mon_err, 0);
`ifdef DVP_CAP_CHECK_EN
        check("b2b_err", {30'd0, err_line_len, err_frame_len}, 32'd0);
`endif

        // odd and over-long lines
        reset_pulse();
        snap();
        vsync_pulse();
        send_line(0, 2 * H);
        send_line(1, 2 * H + 1);
        send_line(2, 2 * H + 2);
        check("odd_pix",    n_pix - p0, 12);
        check("odd_eol",    n_eol - l0, 3);
        check("odd_eof",    n_eof - f0, 1);
        check("odd_fcnt",   frame_cnt, 1);
        check("odd_stream", mon_err, 0);
`ifdef DVP_CAP_CHECK_EN
        check("odd_err_line",  {31'd0, err_line_len}, 1);
        check("odd_err_frame", {31'd0, err_frame_len}, 0);
`endif

        // aborted frame followed by a full frame
        reset_pulse();
        snap();
        vsync_pulse();
        send_line(0, 2 * H);
        send_line(1, 2 * H);
        vsync_pulse();
        check("abort_fcnt", frame_cnt, 0);
        check("abort_eof",  n_eof - f0, 0);
        for (int l = 0; l < V; l++) send_line(l, 2 * H);
        check("abort_next_fcnt", frame_cnt, 1);
        check("abort_next_eof",  n_eof - f0, 1);
        check("abort_sof",       n_sof - s0, 2);
        check("abort_pix",       n_pix - p0, 20);
        check("abort_stream",    mon_err, 0);
`ifdef DVP_CAP_CHECK_EN
        check("abort_err_frame", {31'd0, err_frame_len}, 1);
`endif

        // reset in the middle of a frame
        vsync_pulse();
        send_line(0, 2 * H);
        reset_pulse();
        @(negedge pclk);
        check_zero("midrst");
        snap();
        send_line(1, 2 * H);
        send_line(2, 2 * H);
        check("midrst_quiet", n_pix - p0, 0);
        send_frame();
        check("midrst_pix",    n_pix - p0, 12);
        check("midrst_eof",    n_eof - f0, 1);
        check("midrst_fcnt",   frame_cnt, 1);
        check("midrst_stream", mon_err, 0);

        // enable low at frame start, then high again
        enable = 1'b0;
        snap();
        send_frame();
        check("dis_pix",  n_pix - p0, 0);
        check("dis_fcnt", frame_cnt, 1);
        enable = 1'b1;
        snap();
        send_frame();
        check("ena_pix",  n_pix - p0, 12);
        check("ena_fcnt", frame_cnt, 2);

        // enable dropped mid-frame: frame completes, next one is skipped
        snap();
        vsync_pulse();
        send_line(0, 2 * H);
        enable = 1'b0;
        send_line(1, 2 * H);
        send_line(2, 2 * H);
        check("drop_pix",  n_pix - p0, 12);
        check("drop_fcnt", frame_cnt, 3);
        snap();
        send_frame();
        check("drop_next_pix", n_pix - p0, 0);
        check("drop_next_fcnt", frame_cnt, 3);
        check("final_stream",  mon_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
